button_event_decoder: RTL and testbench

Classifies the debounced push-button level into single-cycle gesture events: press, release, single click, double click and long press. It sits directly downstream of the debouncer's `clean` output in the lab top level. It drives one-cycle strobes into control logic such as mode select and counter stepping, so that logic never sees raw levels.

---
 rtl/btn_event_pkg.sv | 19 +
 rtl/edge_detect.sv | 23 ++
 rtl/button_event_decoder.sv | 127 ++++++++++++
 tb/tb_button_event_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the push-button gesture decoder.
package btn_event_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StLong   = 3'd2,
    StGap    = 3'd3,
    StPress2 = 3'd4
  } state_e;

  // Width of a counter able to hold the larger of two cycle limits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rise/fall strobes for a signal already synchronous to clk.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_p,
  output logic fall_p,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      q      <= d;
      rise_p <= d & ~q;
      fall_p <= ~d & q;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/single/double/long strobes.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_CNT = 50_000_000,
  parameter int unsigned DBL_GAP  = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clean,
  output logic press_p,
  output logic release_p,
  output logic single_p,
  output logic double_p,
  output logic long_p,
  output logic held
);

  localparam int unsigned  CntW    = cnt_width(LONG_CNT, DBL_GAP);
  localparam logic [CntW-1:0] LongVal = CntW'(LONG_CNT);
  localparam logic [CntW-1:0] GapVal  = CntW'(DBL_GAP);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic clean_q;
  logic rise;
  logic fall;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (clean),
    .rise_p (press_p),
    .fall_p (release_p),
    .q      (clean_q)
  );

  // The FSM reacts on the same edge the strobes are registered, so it needs the
  // unregistered edge terms.
  assign rise = clean & ~clean_q;
  assign fall = ~clean & clean_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            single_d, double_d, long_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StPress1;
          cnt_d   = CntOne;
        end
      end
      StPress1: begin
        if (fall) begin
          state_d = StGap;
          cnt_d   = CntOne;
        end else if (clean) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LongVal) begin
            long_d  = 1'b1;
            state_d = StLong;
          end
        end
      end
      StLong: begin
        if (fall) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StGap: begin
        // A rise on the timeout edge still counts as the second press.
        if (rise) begin
          state_d = StPress2;
          cnt_d   = '0;
        end else if (!clean) begin
          cnt_d = cnt_inc;
          if (cnt_inc == GapVal) begin
            single_d = 1'b1;
            state_d  = StIdle;
            cnt_d    = '0;
          end
        end
      end
      StPress2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = StIdle;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      single_p <= 1'b0;
      double_p <= 1'b0;
      long_p   <= 1'b0;
      held     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_p <= single_d;
      double_p <= double_d;
      long_p   <= long_d;
      held     <= (state_d == StLong);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed-vector bench: each step drives clean/rst on the falling edge and checks all outputs.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst;
  logic clean;
  logic press_p, release_p, single_p, double_p, long_p, held;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    ei       = 0;
  string cur      = "";

  // Output vector bit positions: {press, release, single, double, long, held}
  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] R = 6'b010000;
  localparam logic [5:0] S = 6'b001000;
  localparam logic [5:0] D = 6'b000100;
  localparam logic [5:0] L = 6'b000010;
  localparam logic [5:0] H = 6'b000001;

  button_event_decoder #(
    .LONG_CNT (8),
    .DBL_GAP  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clean     (clean),
    .press_p   (press_p),
    .release_p (release_p),
    .single_p  (single_p),
    .double_p  (double_p),
    .long_p    (long_p),
    .held      (held)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs[5:0], exp[5:0]);
    end
  endtask

  task automatic start(input string name);
    cur = name;
    ei  = 0;
  endtask

  // Drive one sample, then check outputs just after the edge that samples it.
  task automatic step(input logic lvl, input logic r, input logic [5:0] exp);
    @(negedge clk);
    clean = lvl;
    rst   = r;
    @(posedge clk);
    #1;
    check($sformatf("%s e%0d", cur, ei),
          {26'd0, press_p, release_p, single_p, double_p, long_p, held}, {26'd0, exp});
    ei++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, N);
  endtask

  initial begin
    rst   = 1'b1;
    clean = 1'b0;

    start("reset");
    step(1'b0, 1'b1, N);
    step(1'b0, 1'b1, N);
    step(1'b0, 1'b0, N);

    start("short");
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R);
    step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, S);
    quiet(2);

    start("long");
    step(1'b1, 1'b0, P);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, N);
    step(1'b1, 1'b0, L | H);
    for (int i = 8; i <= 11; i++) step(1'b1, 1'b0, H);
    step(1'b0, 1'b0, R);
    quiet(8);

    start("double");
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R);
    step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, N);
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R | D);
    quiet(7);

    start("gap5");
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R);
    for (int i = 3; i <= 6; i++) step(1'b0, 1'b0, N);
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R | D);
    quiet(7);

    start("gap6");
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R);
    for (int i = 3; i <= 6; i++) step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, S);
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b0, 1'b0, R);
    for (int i = 11; i <= 14; i++) step(1'b0, 1'b0, N);
    step(1'b0, 1'b0, S);
    quiet(2);

    start("rst_mid");
    step(1'b1, 1'b0, P);
    step(1'b1, 1'b0, N);
    step(1'b1, 1'b0, N);
    step(1'b1, 1'b1, N);
    step(1'b1, 1'b1, N);
    step(1'b1, 1'b0, P);
    for (int i = 6; i <= 11; i++) step(1'b1, 1'b0, N);
    step(1'b1, 1'b0, L | H);
    step(1'b0, 1'b0, R);
    quiet(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
